// File: rtl/font_rom_arbiter_pkg.sv
// rtl/font_rom_arbiter_pkg.sv - font ROM geometry, pipeline tag type and id helpers
// Purpose: constants shared by the font ROM arbiter files.
// Ports: none (package).
package font_rom_arbiter_pkg;

   localparam int FONT_ADDR_W    = 15;
   localparam int FONT_PIX_W     = 6;
   localparam int FONT_WORD_W    = 24;
   // 7920 ROM words, each packing FONT_WORD_W / FONT_PIX_W pixels
   localparam int FONT_PIX_DEPTH = 7920 * (FONT_WORD_W / FONT_PIX_W);
   localparam int ROM_LATENCY    = 1;

   // Requester ids are carried at the widest supported size so that every
   // index into an 8-bit mask is exactly 3 bits wide.
   localparam int MAX_REQ = 8;
   localparam int ID_W    = 3;

   typedef logic [ID_W-1:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
      logic    oob;
   } tag_t;

   function automatic logic [MAX_REQ-1:0] onehot(input req_id_t id);
      return MAX_REQ'(1) << id;
   endfunction

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/font_rom_arbiter_if.sv
// rtl/font_rom_arbiter_if.sv - requester-side request/response bundle of the font ROM arbiter
// Purpose: groups the per-requester request and response signals.
// Ports (signals): req_valid, req_addr (15 bits per requester), req_ready (one-hot grant),
//                  rsp_valid (one-hot pulse), rsp_pixel.
// Modports: master = requesters, slave = arbiter.
interface font_rom_arbiter_if #(
   parameter int N_REQ = 4
);
   import font_rom_arbiter_pkg::*;

   logic [N_REQ-1:0]             req_valid;
   logic [FONT_ADDR_W*N_REQ-1:0] req_addr;
   logic [N_REQ-1:0]             req_ready;
   logic [N_REQ-1:0]             rsp_valid;
   logic [FONT_PIX_W-1:0]        rsp_pixel;

   modport master (
      output req_valid, req_addr,
      input  req_ready, rsp_valid, rsp_pixel
   );

   modport slave (
      input  req_valid, req_addr,
      output req_ready, rsp_valid, rsp_pixel
   );

endinterface

// File: rtl/font_rom_arbiter_rr.sv
// rtl/font_rom_arbiter_rr.sv - round-robin grant search with registered pointer
// Purpose: finds the first valid, eligible requester at or after ptr (with wrap) and
//          moves ptr to the next eligible index after each grant it actually issues.
// Ports: clk, rst   clock, synchronous active-high reset
//        valid      per-requester request
//        block      the RR result is not used this cycle (reset or priority grant); ptr holds
//        found, id  an eligible requester is valid, and which one
module font_rom_arbiter_rr
   import font_rom_arbiter_pkg::*;
#(
   parameter int                 N_REQ     = 4,
   parameter logic [MAX_REQ-1:0] ELIG_MASK = '1,
   parameter req_id_t            PTR_RST   = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] valid,
   input  logic             block,
   output logic             found,
   output req_id_t          id
);

   req_id_t            ptr;
   req_id_t            next_ptr;
   req_id_t            cand;
   req_id_t            ncand;
   logic               next_found;
   logic [MAX_REQ-1:0] valid_ext;

   assign valid_ext = MAX_REQ'(valid);

   always_comb begin
      found = 1'b0;
      id    = '0;
      cand  = '0;
      for (int off = 0; off < N_REQ; off++) begin
         cand = req_id_t'((int'(ptr) + off) % N_REQ);
         if (!found && ELIG_MASK[cand] && valid_ext[cand]) begin
            found = 1'b1;
            id    = cand;
         end
      end
   end

   // Next eligible index strictly after the winner; the mask skips requester 0
   // when it is served by the priority path instead.
   always_comb begin
      next_ptr   = ptr;
      next_found = 1'b0;
      ncand      = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         ncand = req_id_t'((int'(id) + off) % N_REQ);
         if (!next_found && ELIG_MASK[ncand]) begin
            next_found = 1'b1;
            next_ptr   = ncand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= PTR_RST;
      end else if (found && !block) begin
         ptr <= next_ptr;
      end
   end

endmodule

// File: rtl/font_rom_arbiter.sv
// rtl/font_rom_arbiter.sv - shares the single-port font ROM between N_REQ text renderers
// Purpose: one ROM access per cycle, requester 0 optionally fixed-priority, the rest
//          round-robin; each returned pixel is routed back with a one-hot valid
//          at a fixed latency of three edges from accept.
// Ports: clk, rst    clock, synchronous active-high reset
//        bus         font_rom_arbiter_if.slave (requests in, grants and responses out)
//        rom_addr    registered pixel address to font_rom
//        rom_pixel   font_rom registered pixel output
module font_rom_arbiter
   import font_rom_arbiter_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int HIPRI0    = 1,
   parameter int PIX_DEPTH = FONT_PIX_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   font_rom_arbiter_if.slave      bus,
   output logic [FONT_ADDR_W-1:0] rom_addr,
   input  logic [FONT_PIX_W-1:0]  rom_pixel
);

   localparam logic [MAX_REQ-1:0] REQ_MASK  = MAX_REQ'((1 << N_REQ) - 1);
   localparam logic [MAX_REQ-1:0] ELIG_MASK = (HIPRI0 != 0) ? (REQ_MASK & ~MAX_REQ'(1)) : REQ_MASK;
   localparam req_id_t            PTR_RST   = (HIPRI0 != 0) ? req_id_t'(1) : req_id_t'(0);

   logic                   prio;
   logic                   rr_found;
   req_id_t                rr_id;
   logic                   gnt_any;
   req_id_t                gnt_id;
   logic [FONT_ADDR_W-1:0] sel_addr;
   logic                   oob;
   tag_t                   tag_q [0:ROM_LATENCY];
   logic [N_REQ-1:0]       rsp_valid_q;
   logic [FONT_PIX_W-1:0]  rsp_pixel_q;

   assign prio = (HIPRI0 != 0) && bus.req_valid[0];

   font_rom_arbiter_rr #(
      .N_REQ     (N_REQ),
      .ELIG_MASK (ELIG_MASK),
      .PTR_RST   (PTR_RST)
   ) u_rr (
      .clk   (clk),
      .rst   (rst),
      .valid (bus.req_valid),
      .block (rst || prio),
      .found (rr_found),
      .id    (rr_id)
   );

   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      if (!rst) begin
         if (prio) begin
            gnt_any = 1'b1;
         end else if (rr_found) begin
            gnt_any = 1'b1;
            gnt_id  = rr_id;
         end
      end
   end

   assign bus.req_ready = gnt_any ? N_REQ'(onehot(gnt_id)) : '0;

   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_id == req_id_t'(i)) begin
            sel_addr = bus.req_addr[FONT_ADDR_W*i +: FONT_ADDR_W];
         end
      end
   end

   // Out-of-range addresses are still accepted; they read word 0 and the
   // pixel is blanked on the way back.
   assign oob = int'(sel_addr) >= PIX_DEPTH;

   // tag_q[0] lines up with rom_addr, tag_q[ROM_LATENCY] with rom_pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         rom_addr    <= '0;
         rsp_valid_q <= '0;
         rsp_pixel_q <= '0;
         for (int i = 0; i <= ROM_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         if (gnt_any) begin
            rom_addr <= oob ? '0 : sel_addr;
         end
         tag_q[0] <= '{valid: gnt_any, id: gnt_id, oob: oob};
         for (int i = 1; i <= ROM_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         rsp_valid_q <= tag_q[ROM_LATENCY].valid ? N_REQ'(onehot(tag_q[ROM_LATENCY].id)) : '0;
         if (tag_q[ROM_LATENCY].valid) begin
            rsp_pixel_q <= tag_q[ROM_LATENCY].oob ? '0 : rom_pixel;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_pixel = rsp_pixel_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb/tb_font_rom_arbiter.sv - self-checking bench for font_rom_arbiter (priority and pure round-robin builds)
// Purpose: drives both builds with a behavioural ROM (pixel = addr[5:0]) and a response scoreboard.
// Ports: none (top-level bench).
module tb_font_rom_arbiter;

   typedef struct {
      int         due;
      logic [3:0] vld;
      logic [5:0] pix;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   exp_t        q_hp[$];
   exp_t        q_rr[$];

   logic [14:0] hp_rom_addr;
   logic [5:0]  hp_rom_pixel;
   logic [14:0] rr_rom_addr;
   logic [5:0]  rr_rom_pixel;

   font_rom_arbiter_if #(.N_REQ(4)) hp_if ();
   font_rom_arbiter_if #(.N_REQ(4)) rr_if ();

   font_rom_arbiter #(.N_REQ(4), .HIPRI0(1), .PIX_DEPTH(31680)) dut_hp (
      .clk       (clk),
      .rst       (rst),
      .bus       (hp_if),
      .rom_addr  (hp_rom_addr),
      .rom_pixel (hp_rom_pixel)
   );

   font_rom_arbiter #(.N_REQ(4), .HIPRI0(0), .PIX_DEPTH(31680)) dut_rr (
      .clk       (clk),
      .rst       (rst),
      .bus       (rr_if),
      .rom_addr  (rr_rom_addr),
      .rom_pixel (rr_rom_pixel)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc          <= cyc + 1;
      hp_rom_pixel <= hp_rom_addr[5:0];
      rr_rom_pixel <= rr_rom_addr[5:0];
   end

   function automatic logic [5:0] model_pix(input logic [14:0] a);
      return (int'(a) >= 31680) ? 6'd0 : a[5:0];
   endfunction

   function automatic logic [59:0] pack(input int a0, input int a1, input int a2, input int a3);
      return {15'(a3), 15'(a2), 15'(a1), 15'(a0)};
   endfunction

   task automatic monitor();
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            logic [3:0] v;
            logic [5:0] p;
            exp_t       e;
            bit         have;
            v    = (k == 1) ? rr_if.rsp_valid : hp_if.rsp_valid;
            p    = (k == 1) ? rr_if.rsp_pixel : hp_if.rsp_pixel;
            have = 1'b0;
            if (k == 0 && q_hp.size() > 0 && q_hp[0].due == cyc) begin
               e = q_hp.pop_front();
               have = 1'b1;
            end
            if (k == 1 && q_rr.size() > 0 && q_rr[0].due == cyc) begin
               e = q_rr.pop_front();
               have = 1'b1;
            end
            checks++;
            if (have && (v !== e.vld || p !== e.pix)) begin
               failures++;
               $display("FAIL rsp dut=%0d cyc=%0d rsp_valid=%b rsp_pixel=%0d expected rsp_valid=%b rsp_pixel=%0d",
                        k, cyc, v, p, e.vld, e.pix);
            end else if (!have && v !== 4'b0000) begin
               failures++;
               $display("FAIL rsp_idle dut=%0d cyc=%0d rsp_valid=%b expected 0000", k, cyc, v);
            end
         end
      end
   endtask

   // One cycle of stimulus on one build (the other is idled); checks the
   // combinational grant and queues the response due three edges later.
   task automatic drive(input bit rr, input logic [3:0] v, input logic [59:0] a,
                        input int exp_g, input string name);
      logic [3:0] exp_ready;
      logic [3:0] got;
      if (rr) begin
         rr_if.req_valid = v;
         rr_if.req_addr  = a;
         hp_if.req_valid = 4'b0000;
      end else begin
         hp_if.req_valid = v;
         hp_if.req_addr  = a;
         rr_if.req_valid = 4'b0000;
      end
      #1;
      exp_ready = (exp_g < 0) ? 4'b0000 : 4'(1 << exp_g);
      got = rr ? rr_if.req_ready : hp_if.req_ready;
      checks++;
      if (got !== exp_ready) begin
         failures++;
         $display("FAIL %s cyc=%0d req_ready=%b expected %b", name, cyc, got, exp_ready);
      end
      if (exp_g >= 0) begin
         exp_t e;
         e.due = cyc + 3;
         e.vld = exp_ready;
         e.pix = model_pix(a[15*exp_g +: 15]);
         if (rr) q_rr.push_back(e);
         else    q_hp.push_back(e);
      end
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 4'b0000, '0, -1, "idle");
   endtask

   task automatic do_reset(input logic [3:0] v, input int n);
      rst = 1'b1;
      hp_if.req_valid = v;
      rr_if.req_valid = v;
      q_hp.delete();
      q_rr.delete();
      #1;
      checks++;
      if (hp_if.req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL ready_in_rst_hp req_ready=%b expected 0000", hp_if.req_ready);
      end
      checks++;
      if (rr_if.req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL ready_in_rst_rr req_ready=%b expected 0000", rr_if.req_ready);
      end
      repeat (n) begin
         @(negedge clk);
         #1;
      end
      rst = 1'b0;
      hp_if.req_valid = 4'b0000;
      rr_if.req_valid = 4'b0000;
   endtask

   task automatic test_reset();
      do_reset(4'b0000, 2);
      checks++;
      if (hp_rom_addr !== 15'd0) begin
         failures++;
         $display("FAIL reset_rom_addr_hp rom_addr=%0d expected 0", hp_rom_addr);
      end
      checks++;
      if (rr_rom_addr !== 15'd0) begin
         failures++;
         $display("FAIL reset_rom_addr_rr rom_addr=%0d expected 0", rr_rom_addr);
      end
      checks++;
      if (hp_if.rsp_valid !== 4'b0000 || hp_if.rsp_pixel !== 6'd0) begin
         failures++;
         $display("FAIL reset_rsp_hp rsp_valid=%b rsp_pixel=%0d expected 0000 0", hp_if.rsp_valid, hp_if.rsp_pixel);
      end
      checks++;
      if (rr_if.rsp_valid !== 4'b0000 || rr_if.rsp_pixel !== 6'd0) begin
         failures++;
         $display("FAIL reset_rsp_rr rsp_valid=%b rsp_pixel=%0d expected 0000 0", rr_if.rsp_valid, rr_if.rsp_pixel);
      end
   endtask

   task automatic test_single();
      drive(1'b0, 4'b0100, pack(0, 0, 5, 0), 2, "single");
      checks++;
      if (hp_rom_addr !== 15'd5) begin
         failures++;
         $display("FAIL single_rom_addr rom_addr=%0d expected 5", hp_rom_addr);
      end
      idle(5);
   endtask

   task automatic test_priority();
      int seq [4] = '{1, 2, 3, 1};
      do_reset(4'b0000, 1);
      for (int i = 0; i < 6; i++)
         drive(1'b0, 4'b1111, pack(100 + i, 200 + i, 300 + i, 400 + i), 0, "hipri_hold");
      for (int i = 0; i < 4; i++)
         drive(1'b0, 4'b1110, pack(0, 500 + i, 600 + i, 700 + i), seq[i], "hipri_rr");
      idle(4);
   endtask

   task automatic test_round_robin();
      int seq [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++)
         drive(1'b1, 4'b1111, pack(1000 + i, 2000 + i, 3000 + i, 4000 + i), seq[i], "rr_all");
      idle(4);
   endtask

   task automatic test_out_of_range();
      drive(1'b0, 4'b0010, pack(0, 31680, 0, 0), 1, "oob_first");
      checks++;
      if (hp_rom_addr !== 15'd0) begin
         failures++;
         $display("FAIL oob_rom_addr rom_addr=%0d expected 0", hp_rom_addr);
      end
      drive(1'b0, 4'b0010, pack(0, 31679, 0, 0), 1, "oob_last_legal");
      checks++;
      if (hp_rom_addr !== 15'd31679) begin
         failures++;
         $display("FAIL last_legal_rom_addr rom_addr=%0d expected 31679", hp_rom_addr);
      end
      idle(4);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++)
         drive(1'b0, 4'b0001, pack(10 + i, 0, 0, 0), 0, "mid_accept");
      idle(1);
      do_reset(4'b1111, 1);
      idle(5);
      drive(1'b0, 4'b1110, pack(0, 41, 42, 43), 1, "post_rst_hp");
      drive(1'b1, 4'b1111, pack(50, 51, 52, 53), 0, "post_rst_rr");
      idle(4);
   endtask

   task automatic test_idle_hold();
      drive(1'b0, 4'b0100, pack(0, 0, 777, 0), 2, "idle_traffic");
      idle(10);
      checks++;
      if (hp_rom_addr !== 15'd777) begin
         failures++;
         $display("FAIL idle_rom_addr rom_addr=%0d expected 777", hp_rom_addr);
      end
   endtask

   initial begin
      hp_if.req_valid = 4'b0000;
      hp_if.req_addr  = '0;
      rr_if.req_valid = 4'b0000;
      rr_if.req_addr  = '0;
      fork
         monitor();
      join_none
      test_reset();
      test_single();
      test_priority();
      test_round_robin();
      test_out_of_range();
      test_reset_mid();
      test_idle_hold();
      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
